// File: rtl/ex_mul_div.sv
// Iterative 64-bit RISC-V M-extension unit: radix-2 shift-add multiply and
// restoring divide, one iteration per cycle, with pipeline stall/flush handshake.
module ex_mul_div #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stall_req_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_DIVU   = 4'd5;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;
    localparam logic [3:0] OP_MULW   = 4'd8;
    localparam logic [3:0] OP_DIVW   = 4'd9;
    localparam logic [3:0] OP_DIVUW  = 4'd10;
    localparam logic [3:0] OP_REMW   = 4'd11;
    localparam logic [3:0] OP_REMUW  = 4'd12;

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_rem_op(input logic [3:0] op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_sgn1(input logic [3:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic is_sgn2(input logic [3:0] op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    state_e       state_q;
    logic [3:0]   op_q;
    logic [6:0]   cnt_q;
    logic [63:0]  mcand_q;
    logic [127:0] acc_q;
    logic         neg_q;
    logic         rneg_q;
    logic [63:0]  res_q;

    // Operand preparation for the op presented this cycle
    logic        is_w, sgn1, sgn2, x_neg, y_neg, div_zero, div_ovf, accept;
    logic [63:0] x_ext, y_ext, x_mag, y_mag, spec_res;

    always_comb begin
        is_w  = op_i[3];
        sgn1  = is_sgn1(op_i);
        sgn2  = is_sgn2(op_i);
        x_ext = is_w ? {{32{sgn1 & rs1_i[31]}}, rs1_i[31:0]} : rs1_i;
        y_ext = is_w ? {{32{sgn2 & rs2_i[31]}}, rs2_i[31:0]} : rs2_i;
        x_neg = sgn1 & x_ext[63];
        y_neg = sgn2 & y_ext[63];
        x_mag = x_neg ? -x_ext : x_ext;
        y_mag = y_neg ? -y_ext : y_ext;

        div_zero = is_div_op(op_i) && (y_ext == '0);
        div_ovf  = is_div_op(op_i) && sgn1 &&
                   (is_w ? (rs1_i[31:0] == 32'h8000_0000 && rs2_i[31:0] == 32'hFFFF_FFFF)
                         : (rs1_i == 64'h8000_0000_0000_0000 && rs2_i == '1));

        spec_res = '0;
        if (div_zero)
            spec_res = is_rem_op(op_i) ? x_ext : '1;
        else if (div_ovf)
            spec_res = is_rem_op(op_i) ? '0 : x_ext;
        if (is_w)
            spec_res = sext32(spec_res[31:0]);

        accept = (state_q == IDLE) && start_i && !flush_i && (op_i <= OP_REMUW);
    end

    // One iteration step; acc holds {hi,lo} product or {remainder,quotient}
    logic [64:0]  mul_sum, div_trial;
    logic [127:0] mul_nxt, div_nxt, acc_nxt, prod;
    logic [63:0]  quo, rem, fin;

    always_comb begin
        mul_sum   = {1'b0, acc_q[127:64]} + {1'b0, mcand_q};
        mul_nxt   = acc_q[0] ? {mul_sum, acc_q[63:1]} : {1'b0, acc_q[127:1]};
        div_trial = acc_q[127:63] - {1'b0, mcand_q};
        div_nxt   = div_trial[64] ? {acc_q[126:0], 1'b0}
                                  : {div_trial[63:0], acc_q[62:0], 1'b1};
        acc_nxt   = is_div_op(op_q) ? div_nxt : mul_nxt;

        prod = neg_q  ? -acc_nxt          : acc_nxt;
        quo  = neg_q  ? -acc_nxt[63:0]    : acc_nxt[63:0];
        rem  = rneg_q ? -acc_nxt[127:64]  : acc_nxt[127:64];

        case (op_q)
            OP_MUL, OP_MULW:                 fin = prod[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU:    fin = prod[127:64];
            OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW: fin = quo;
            default:                         fin = rem;
        endcase
        if (op_q[3])
            fin = sext32(fin[31:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_i;
                        cnt_q   <= '0;
                        mcand_q <= y_mag;
                        acc_q   <= {64'd0, x_mag};
                        neg_q   <= x_neg ^ y_neg;
                        rneg_q  <= x_neg;
                        if (div_zero || div_ovf) begin
                            res_q   <= spec_res;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == 7'd63) begin
                        res_q   <= fin;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!hold_i)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A flush kills whatever is in flight, including a held result
            if (flush_i)
                state_q <= IDLE;
        end
    end

    assign stall_req_o    = !rst && !flush_i && (accept || state_q == CALC);
    assign result_valid_o = !rst && !flush_i && (state_q == DONE);
    assign result_o       = result_valid_o ? res_q : '0;
    assign busy_o         = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_ex_mul_div.sv
// Directed plus randomized check of ex_mul_div against an arithmetic reference
// model; inputs change just after the falling edge, outputs sampled 1ns later.
module tb_ex_mul_div;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [3:0]  op_i;
    logic [63:0] rs1_i;
    logic [63:0] rs2_i;
    logic        flush_i;
    logic        hold_i;
    logic        stall_req_o;
    logic        result_valid_o;
    logic [63:0] result_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    ex_mul_div #(.XLEN(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .flush_i       (flush_i),
        .hold_i        (hold_i),
        .stall_req_o   (stall_req_o),
        .result_valid_o(result_valid_o),
        .result_o      (result_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: plain signed/unsigned arithmetic plus the divide corner-case rules
    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb;
        logic [127:0] ua, ub, p;
        longint sa64, sb64;
        int sa32, sb32;
        logic [31:0] ua32, ub32, r32;
        logic ovf64, ovf32;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'd0, a};
        ub = {64'd0, b};
        sa64 = a; sb64 = b;
        sa32 = a[31:0]; sb32 = b[31:0];
        ua32 = a[31:0]; ub32 = b[31:0];
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
        case (op)
            4'd0: return a * b;
            4'd1: begin p = sa * sb; return p[127:64]; end
            4'd2: begin p = sa * $signed(ub); return p[127:64]; end
            4'd3: begin p = ua * ub; return p[127:64]; end
            4'd4: begin
                if (b == 0) return '1;
                if (ovf64) return a;
                return sa64 / sb64;
            end
            4'd5: return (b == 0) ? '1 : a / b;
            4'd6: begin
                if (b == 0) return a;
                if (ovf64) return '0;
                return sa64 % sb64;
            end
            4'd7: return (b == 0) ? a : a % b;
            4'd8: begin r32 = sa32 * sb32; return sx32(r32); end
            4'd9: begin
                if (ub32 == 0) return '1;
                if (ovf32) return sx32(ua32);
                r32 = sa32 / sb32; return sx32(r32);
            end
            4'd10: begin
                if (ub32 == 0) return '1;
                r32 = ua32 / ub32; return sx32(r32);
            end
            4'd11: begin
                if (ub32 == 0) return sx32(ua32);
                if (ovf32) return '0;
                r32 = sa32 % sb32; return sx32(r32);
            end
            4'd12: begin
                if (ub32 == 0) return sx32(ua32);
                r32 = ua32 % ub32; return sx32(r32);
            end
            default: return '0;
        endcase
    endfunction

    // Divide-by-zero and signed overflow finish one cycle after accept
    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic w, sgn;
        w   = op >= 4'd8;
        sgn = op inside {4'd4, 4'd6, 4'd9, 4'd11};
        if (!(op inside {[4'd4:4'd7], [4'd9:4'd12]})) return 65;
        if (w ? (b[31:0] == 0) : (b == 0)) return 1;
        if (sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == 64'h8000_0000_0000_0000 && b == '1))) return 1;
        return 65;
    endfunction

    // Issues an op in the current cycle, waits for the result, optionally holds it.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int hold_n);
        logic [63:0] exp;
        int exp_lat, lat, stalls;
        exp     = ref_res(op, a, b);
        exp_lat = ref_lat(op, a, b);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        #1;
        chk("stall_on_accept", 64'(stall_req_o), 64'd1);
        stalls = 1;
        @(negedge clk);
        start_i = 1'b0;
        op_i  = 4'($urandom_range(0, 15));
        rs1_i = {$urandom, $urandom};
        rs2_i = {$urandom, $urandom};
        #1;
        lat = 1;
        while (!result_valid_o && lat < 100) begin
            if (stall_req_o) stalls++;
            @(negedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("stall_cycles", 64'(stalls), 64'(exp_lat));
        chk("result", result_o, exp);
        chk("stall_in_done", 64'(stall_req_o), 64'd0);
        for (int i = 0; i < hold_n; i++) begin
            hold_i = 1'b1;
            #1;
            chk("hold_valid", 64'(result_valid_o), 64'd1);
            chk("hold_result", result_o, exp);
            chk("hold_stall", 64'(stall_req_o), 64'd0);
            @(negedge clk);
        end
        hold_i  = 1'b0;
        start_i = 1'b1; op_i = 4'd0;
        #1;
        chk("done_ignores_start", 64'(stall_req_o), 64'd0);
        chk("done_valid", 64'(result_valid_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("idle_after_done", 64'(busy_o), 64'd0);
        chk("idle_result_zero", result_o, 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b;

        rst = 1'b1; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
        flush_i = 1'b0; hold_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_stall", 64'(stall_req_o), 64'd0);
        chk("rst_valid", 64'(result_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MUL -3 * 7
        run_op(4'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 0);
        chk("mul_neg3x7", ref_res(4'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        // MULHU all-ones squared, then DIVW overflow
        run_op(4'd3, '1, '1, 0);
        run_op(4'd9, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        // DIVU by zero, REM -7/2
        run_op(4'd5, 64'd12345, 64'd0, 0);
        run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
        // REMU 10/3 held 5 cycles in DONE
        run_op(4'd7, 64'd10, 64'd3, 5);

        // Unsupported opcode is ignored
        start_i = 1'b1; op_i = 4'd14; rs1_i = 64'd5; rs2_i = 64'd6;
        #1;
        chk("badop_stall", 64'(stall_req_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("badop_busy", 64'(busy_o), 64'd0);

        // Start together with flush is not accepted
        start_i = 1'b1; op_i = 4'd0; flush_i = 1'b1;
        #1;
        chk("flush_start_stall", 64'(stall_req_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("flush_start_busy", 64'(busy_o), 64'd0);

        // Flush DIV at iteration 20, then MUL right after
        start_i = 1'b1; op_i = 4'd4; rs1_i = 64'd1000; rs2_i = 64'd7;
        #1;
        chk("div_accept_stall", 64'(stall_req_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        #1;
        chk("div_calc_busy", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_stall", 64'(stall_req_o), 64'd0);
        chk("flush_valid", 64'(result_valid_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_idle", 64'(busy_o), 64'd0);
        chk("flush_no_valid", 64'(result_valid_o), 64'd0);
        run_op(4'd0, 64'd123456789, 64'hFFFF_FFFF_FFFF_FF00, 0);

        // Reset pulse at iteration 30 of DIV
        start_i = 1'b1; op_i = 4'd4; rs1_i = 64'hFFFF_0000_1234_5678; rs2_i = 64'd99;
        @(negedge clk);
        start_i = 1'b0;
        repeat (29) @(negedge clk);
        start_i = 1'b1; op_i = 4'd0; rs1_i = 64'd11; rs2_i = 64'd13;
        rst = 1'b1;
        #1;
        chk("midrst_stall", 64'(stall_req_o), 64'd0);
        chk("midrst_valid", 64'(result_valid_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd0, 64'd11, 64'd13, 0);

        // Randomized ops with corner-case operand injection
        for (int k = 0; k < 30; k++) begin
            op = 4'($urandom_range(0, 12));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 64'h8000_0000_0000_0000; b = '1; end
                2: begin a[31:0] = 32'h8000_0000; b[31:0] = 32'hFFFF_FFFF; end
                3: b = 64'($urandom_range(1, 20));
                4: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op(op, a, b, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
